rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
Shares the register file's single byte-enabled write port between NREQ writeback requesters, such as ALU, load unit and multiply/divide. Each requester uses a valid/ready handshake. Grants rotate round-robin. The granted write is captured into one registered output stage that drives the register file's wen/waddr/wdata. Sits between the execute/memory writeback sources and the three-ported register file.

Parameters:
NREQ, 3, number of writeback requesters (2..8)
AW, 5, register address width
DW, 32, data width; byte-enable width is DW/8

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester write request
req_ready  out  NREQ  per-requester accept; one-hot or zero
req_addr  in  NREQ*AW  packed destination addresses, requester i at [i*AW +: AW]
req_be  in  NREQ*DW/8  packed byte enables
req_data  in  NREQ*DW  packed write data
hold  in  1  freeze: no grant, no write, output stage retained
rf_wen  out  DW/8  register file byte write enables
rf_waddr  out  AW  register file write address
rf_wdata  out  DW  register file write data
busy  out  1  output stage holds a pending write
grant_id  out  clog2(NREQ)  index of requester accepted this cycle; valid when |req_ready

Behaviour:
- Reset (async, resetn=0):
  - stage_valid=0, rf_wen=0, rf_waddr=0, rf_wdata=0.
  - Round-robin pointer rr_ptr=0; req_ready=0; busy=0; grant_id=0.
- Output stage: registers st_addr, st_be, st_data and stage_valid.
  - rf_wen = (stage_valid & ~hold) ? st_be : 0.
  - rf_waddr = st_addr; rf_wdata = st_data.
  - busy = stage_valid.
- Drain: the stage retires on any clock edge where stage_valid=1 and hold=0.
- Accept condition: accept = ~hold & (~stage_valid | drain) & |req_valid. The stage refills in the same cycle it drains, so the throughput is 1 write per cycle.
- Grant (combinational):
  - Pick the first valid requester scanning rr_ptr, rr_ptr+1, ... mod NREQ.
  - req_ready[g]=1 only when accept=1. grant_id=g.
- On accept:
  - The stage loads requester g's addr/be/data and stage_valid is set.
  - rr_ptr <= (g+1) mod NREQ.
  - Without accept, rr_ptr is unchanged.
- Latency: the write appears on rf_wen exactly 1 cycle after the handshake, or later if hold is asserted.
- Address 0 (hardwired zero register):
  - The request is handshaken normally; the stage loads st_be=0, so no write occurs.
  - stage_valid is still set for one cycle; busy reflects it.
- req_be=0: accepted, and behaves as a no-op write.
- Requester contract: payload must be stable while valid=1 and ready=0. The arbiter does not require this; it samples only at handshake.
- hold=1 mid-write:
  - rf_wen=0 and the stage is retained.
  - The identical write issues on the first cycle hold=0.
  - No grant occurs during hold.
- Reset mid-operation: the pending stage write is discarded and never issued.
- Fairness: a continuously valid requester waits at most NREQ-1 grants.

Optional Feature:
- Macro: RF_WB_FWD_EN.
- When defined, add ports:
  - fwd_raddr1, fwd_raddr2  in  AW.
  - fwd_rdata1_in, fwd_rdata2_in  in  DW (register file read data).
  - fwd_rdata1, fwd_rdata2  out  DW.
- Forwarding rule: if stage_valid and st_addr==fwd_raddrN and st_addr!=0, each byte with st_be[b]=1 takes st_data; other bytes pass fwd_rdataN_in.
- Forwarding stays active during hold.
- When undefined: ports absent; there is no forwarding logic.

Decomposition:
- Package rf_wb_pkg holds:
  - RF_AW=5, RF_DW=32, RF_BEW=4, RF_ZERO_ADDR=0.
  - Function rr_pick(valid, ptr) returning the index and a found flag.
- One sub-module: rf_wb_rr_arb (NREQ-wide round-robin picker plus pointer register).
- The stage and forwarding stay in the top module.

Test Plan:
- Single write: req0 valid addr=5 be=F data=0x12345678 → ready0 same cycle; next cycle rf_wen=F, waddr=5, wdata=0x12345678; busy=1 that cycle only.
- All 3 requesters valid continuously from reset → grants 0,1,2,0,1,2 on consecutive cycles; one rf write per cycle.
- hold=1 for 3 cycles with the stage loaded → rf_wen=0 and no req_ready for 3 cycles; the write issues on the cycle after hold drops, exactly once.
- addr=0, be=F → handshake occurs; next cycle rf_wen=0; busy=1 for one cycle.
- Byte enable: be=4'b0101, data=0xAABBCCDD → rf_wen=0101, wdata=0xAABBCCDD.
- resetn pulsed low while the stage is loaded → rf_wen=0 immediately; no write after release; the next grant goes to requester 0. With RF_WB_FWD_EN defined: stage addr=7 be=0011 data=0x0000BEEF, fwd_raddr1=7, fwd_rdata1_in=0x11223344 → fwd_rdata1=0x1122BEEF.

Source files
------------

// File: rtl/rf_wb_pkg.sv
// ---------------------------------------------------------------------------
// rf_wb_pkg
// Shared constants and helpers for the register-file writeback arbiter.
//   RF_AW / RF_DW / RF_BEW : default address, data and byte-enable widths
//   RF_ZERO_ADDR           : hardwired-zero register address (writes dropped)
//   rr_pick()              : round-robin scan of up to RR_MAX requesters
// ---------------------------------------------------------------------------
package rf_wb_pkg;

    localparam int RF_AW        = 5;
    localparam int RF_DW        = 32;
    localparam int RF_BEW       = 4;
    localparam int RF_ZERO_ADDR = 0;

    // Widest requester count the picker supports
    localparam int RR_MAX = 8;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    // Scan ptr, ptr+1, ... modulo n and return the first valid requester.
    // Entries at or above n are never considered.
    function automatic rr_pick_t rr_pick(input logic [7:0] valid,
                                         input logic [2:0] ptr,
                                         input int         n);
        rr_pick_t res;
        int       cand;
        res = '0;
        for (int k = 0; k < RR_MAX; k++) begin
            cand = (int'(ptr) + k) % n;
            if ((k < n) && !res.found && valid[cand[2:0]]) begin
                res.found = 1'b1;
                res.idx   = cand[2:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rf_wb_rr_arb.sv
// ---------------------------------------------------------------------------
// rf_wb_rr_arb
// Round-robin picker for NREQ requesters plus its rotating pointer.
// Ports:
//   clk_i      : clock, rising edge
//   resetn_i   : asynchronous active-low reset (pointer returns to 0)
//   valid_i    : per-requester request vector
//   advance_i  : a grant was taken this cycle; move pointer past the winner
//   found_o    : at least one requester is valid
//   grantId_o  : index of the winning requester
// ---------------------------------------------------------------------------
module rf_wb_rr_arb
    import rf_wb_pkg::*;
#(
    parameter  int NREQ = 3,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk_i,
    input  logic            resetn_i,
    input  logic [NREQ-1:0] valid_i,
    input  logic            advance_i,
    output logic            found_o,
    output logic [IW-1:0]   grantId_o
);

    logic [IW-1:0] rrPtr_q;
    logic [IW-1:0] rrPtr_d;
    logic [7:0]    validPad;
    logic [2:0]    ptrPad;
    rr_pick_t      pick;
    logic [3:0]    nextIdx;

    // Widen to the picker's fixed width, pick a winner, and compute where
    // the pointer goes if that winner is actually accepted.
    always_comb begin
        validPad               = '0;
        validPad[NREQ-1:0]     = valid_i;
        ptrPad                 = '0;
        ptrPad[IW-1:0]         = rrPtr_q;
        pick                   = rr_pick(validPad, ptrPad, NREQ);
        nextIdx                = {1'b0, pick.idx} + 4'd1;
        rrPtr_d                = rrPtr_q;
        if (advance_i) begin
            rrPtr_d = (nextIdx == 4'(NREQ)) ? '0 : nextIdx[IW-1:0];
        end
    end

    assign found_o   = pick.found;
    assign grantId_o = pick.idx[IW-1:0];

    // Pointer only moves when a grant is taken, so priority is preserved
    // across hold cycles and idle cycles.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            rrPtr_q <= '0;
        end else begin
            rrPtr_q <= rrPtr_d;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter
// Shares the register file's single byte-enabled write port between NREQ
// writeback requesters. Round-robin grant, one registered output stage that
// drains and refills in the same cycle (one write per cycle).
// Optional macro RF_WB_FWD_EN adds two read-port bypass paths from the stage.
// Ports:
//   clk, resetn           : clock (rising) and async active-low reset
//   req_valid/req_ready   : per-requester handshake (ready is one-hot or 0)
//   req_addr/be/data      : packed payloads, requester i at [i*W +: W]
//   hold                  : freeze; no grant, no write, stage retained
//   rf_wen/waddr/wdata    : register file write port
//   busy                  : stage holds a pending write
//   grant_id              : winner index, meaningful when |req_ready
//   fwd_* (RF_WB_FWD_EN)  : read addresses, raw RF data in, bypassed data out
// ---------------------------------------------------------------------------
module rf_wb_arbiter
    import rf_wb_pkg::*;
#(
    parameter  int NREQ = 3,
    parameter  int AW   = RF_AW,
    parameter  int DW   = RF_DW,
    localparam int BEW  = DW / 8,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*AW-1:0]  req_addr,
    input  logic [NREQ*BEW-1:0] req_be,
    input  logic [NREQ*DW-1:0]  req_data,
    input  logic                hold,
    output logic [BEW-1:0]      rf_wen,
    output logic [AW-1:0]       rf_waddr,
    output logic [DW-1:0]       rf_wdata,
    output logic                busy,
    output logic [IW-1:0]       grant_id
`ifdef RF_WB_FWD_EN
    ,
    input  logic [AW-1:0]       fwd_raddr1,
    input  logic [AW-1:0]       fwd_raddr2,
    input  logic [DW-1:0]       fwd_rdata1_in,
    input  logic [DW-1:0]       fwd_rdata2_in,
    output logic [DW-1:0]       fwd_rdata1,
    output logic [DW-1:0]       fwd_rdata2
`endif
);

    logic           stageValid_q;
    logic [AW-1:0]  stAddr_q;
    logic [BEW-1:0] stBe_q;
    logic [DW-1:0]  stData_q;

    logic           drain;
    logic           accept;
    logic           found;
    logic [IW-1:0]  pickId;
    logic [AW-1:0]  selAddr;
    logic [BEW-1:0] selBe;
    logic [DW-1:0]  selData;

    rf_wb_rr_arb #(
        .NREQ (NREQ)
    ) u_rr (
        .clk_i     (clk),
        .resetn_i  (resetn),
        .valid_i   (req_valid),
        .advance_i (accept),
        .found_o   (found),
        .grantId_o (pickId)
    );

    // The stage can take a new write whenever it is empty or draining this
    // edge; gating with resetn keeps req_ready low while reset is asserted.
    assign drain  = stageValid_q & ~hold;
    assign accept = resetn & ~hold & (~stageValid_q | drain) & found;

    assign grant_id = accept ? pickId : '0;

    // One-hot ready to the winner and a payload mux selected by the same index
    always_comb begin
        req_ready = '0;
        selAddr   = '0;
        selBe     = '0;
        selData   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IW'(i) == pickId) begin
                req_ready[i] = accept;
                selAddr      = req_addr[i*AW +: AW];
                selBe        = req_be[i*BEW +: BEW];
                selData      = req_data[i*DW +: DW];
            end
        end
    end

    // Output stage. Writes to the zero register are accepted but loaded with
    // no byte enables so they occupy the stage for one cycle and write nothing.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stageValid_q <= 1'b0;
            stAddr_q     <= '0;
            stBe_q       <= '0;
            stData_q     <= '0;
        end else if (accept) begin
            stageValid_q <= 1'b1;
            stAddr_q     <= selAddr;
            stBe_q       <= (selAddr == AW'(RF_ZERO_ADDR)) ? '0 : selBe;
            stData_q     <= selData;
        end else if (drain) begin
            stageValid_q <= 1'b0;
        end
    end

    assign rf_wen   = (stageValid_q & ~hold) ? stBe_q : '0;
    assign rf_waddr = stAddr_q;
    assign rf_wdata = stData_q;
    assign busy     = stageValid_q;

`ifdef RF_WB_FWD_EN
    logic hit1;
    logic hit2;

    // Bypass stays live under hold: the pending write is still the newest value.
    assign hit1 = stageValid_q && (stAddr_q == fwd_raddr1) && (stAddr_q != AW'(RF_ZERO_ADDR));
    assign hit2 = stageValid_q && (stAddr_q == fwd_raddr2) && (stAddr_q != AW'(RF_ZERO_ADDR));

    // Per-byte merge: enabled bytes come from the stage, others from the RF
    always_comb begin
        fwd_rdata1 = fwd_rdata1_in;
        fwd_rdata2 = fwd_rdata2_in;
        for (int b = 0; b < BEW; b++) begin
            if (hit1 && stBe_q[b]) fwd_rdata1[b*8 +: 8] = stData_q[b*8 +: 8];
            if (hit2 && stBe_q[b]) fwd_rdata2[b*8 +: 8] = stData_q[b*8 +: 8];
        end
    end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_wb_arbiter
// Self-checking bench for rf_wb_arbiter (NREQ=3, AW=5, DW=32): a table of
// hand-derived cycle vectors, hand sequences for async reset and forwarding
// (RF_WB_FWD_EN), then randomized traffic against a behavioural model.
// ---------------------------------------------------------------------------
module tb_rf_wb_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int BEW  = 4;

    logic                clk = 1'b0;
    logic                resetn;
    logic [NREQ-1:0]     reqValid;
    logic [NREQ-1:0]     reqReady;
    logic [NREQ*AW-1:0]  reqAddr;
    logic [NREQ*BEW-1:0] reqBe;
    logic [NREQ*DW-1:0]  reqData;
    logic                hold;
    logic [BEW-1:0]      rfWen;
    logic [AW-1:0]       rfWaddr;
    logic [DW-1:0]       rfWdata;
    logic                busy;
    logic [1:0]          grantId;
`ifdef RF_WB_FWD_EN
    logic [AW-1:0]       fwdRaddr1 = '0;
    logic [AW-1:0]       fwdRaddr2 = '0;
    logic [DW-1:0]       fwdRdata1In = '0;
    logic [DW-1:0]       fwdRdata2In = '0;
    logic [DW-1:0]       fwdRdata1;
    logic [DW-1:0]       fwdRdata2;
`endif

    rf_wb_arbiter #(
        .NREQ (NREQ),
        .AW   (AW),
        .DW   (DW)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .req_valid     (reqValid),
        .req_ready     (reqReady),
        .req_addr      (reqAddr),
        .req_be        (reqBe),
        .req_data      (reqData),
        .hold          (hold),
        .rf_wen        (rfWen),
        .rf_waddr      (rfWaddr),
        .rf_wdata      (rfWdata),
        .busy          (busy),
        .grant_id      (grantId)
`ifdef RF_WB_FWD_EN
        ,
        .fwd_raddr1    (fwdRaddr1),
        .fwd_raddr2    (fwdRaddr2),
        .fwd_rdata1_in (fwdRdata1In),
        .fwd_rdata2_in (fwdRdata2In),
        .fwd_rdata1    (fwdRdata1),
        .fwd_rdata2    (fwdRdata2)
`endif
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;

    typedef struct {
        logic [2:0]  valid;
        logic [14:0] addr;
        logic [11:0] be;
        logic [95:0] data;
        logic        hold;
        logic [2:0]  expReady;
        logic [1:0]  expGid;
        logic [3:0]  expWen;
        logic [4:0]  expAddr;
        logic [31:0] expData;
        logic        expBusy;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    // Payload used whenever all three requesters are active together
    localparam logic [14:0] ALL_ADDR = {5'd3, 5'd2, 5'd1};
    localparam logic [11:0] ALL_BE   = 12'hFFF;
    localparam logic [95:0] ALL_DATA = {32'h300, 32'h200, 32'h100};

    // Behavioural model state
    logic        mValid;
    logic [4:0]  mAddr;
    logic [3:0]  mBe;
    logic [31:0] mData;
    int          mPtr;
    int          g;
    int          idx;
    logic        acc;
    logic [2:0]  rv;
    logic [14:0] ra;
    logic [11:0] rb;
    logic [95:0] rd;
    logic        rh;
    logic [2:0]  expR;
    logic [1:0]  expG;
    logic [3:0]  expW;

    task automatic setVec(input int i, input logic [2:0] v, input logic [14:0] a,
                          input logic [11:0] b, input logic [95:0] d, input logic h,
                          input logic [2:0] r, input logic [1:0] gid, input logic [3:0] w,
                          input logic [4:0] wa, input logic [31:0] wd, input logic bz);
        vecs[i].valid    = v;
        vecs[i].addr     = a;
        vecs[i].be       = b;
        vecs[i].data     = d;
        vecs[i].hold     = h;
        vecs[i].expReady = r;
        vecs[i].expGid   = gid;
        vecs[i].expWen   = w;
        vecs[i].expAddr  = wa;
        vecs[i].expData  = wd;
        vecs[i].expBusy  = bz;
    endtask

    // Drive one cycle of inputs just after the rising edge
    task automatic applyStimulus(input logic [2:0] v, input logic [14:0] a,
                                 input logic [11:0] b, input logic [95:0] d,
                                 input logic h);
        @(posedge clk);
        #1;
        reqValid = v;
        reqAddr  = a;
        reqBe    = b;
        reqData  = d;
        hold     = h;
    endtask

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // grant_id is only meaningful alongside a ready, so it is compared only then
    task automatic checkOutput(input string tag, input logic [2:0] r, input logic [1:0] gid,
                               input logic [3:0] w, input logic [4:0] wa,
                               input logic [31:0] wd, input logic bz);
        checkField({tag, ".req_ready"}, 32'(reqReady), 32'(r));
        if (r != 3'b000) checkField({tag, ".grant_id"}, 32'(grantId), 32'(gid));
        checkField({tag, ".rf_wen"},   32'(rfWen),   32'(w));
        checkField({tag, ".rf_waddr"}, 32'(rfWaddr), 32'(wa));
        checkField({tag, ".rf_wdata"}, rfWdata,      wd);
        checkField({tag, ".busy"},     32'(busy),    32'(bz));
    endtask

    initial begin
        resetn   = 1'b0;
        reqValid = '0;
        reqAddr  = '0;
        reqBe    = '0;
        reqData  = '0;
        hold     = 1'b0;

        // Requests during reset must not be granted
        reqValid = 3'b111;
        #12;
        checkOutput("reset", 3'b000, 2'd0, 4'h0, 5'd0, 32'h0, 1'b0);
        reqValid = '0;
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // Cycle vectors from reset: single write, retention, zero register,
        // partial byte enables, rotation, and a 3-cycle hold.
        setVec( 0, 3'b000, 15'd0, 12'h0, 96'h0, 1'b0, 3'b000, 2'd0, 4'h0, 5'd0, 32'h0,        1'b0);
        setVec( 1, 3'b001, {10'd0, 5'd5}, 12'h00F, {64'h0, 32'h12345678}, 1'b0,
                   3'b001, 2'd0, 4'h0, 5'd0, 32'h0,        1'b0);
        setVec( 2, 3'b000, 15'd0, 12'h0, 96'h0, 1'b0, 3'b000, 2'd0, 4'hF, 5'd5, 32'h12345678, 1'b1);
        setVec( 3, 3'b000, 15'd0, 12'h0, 96'h0, 1'b0, 3'b000, 2'd0, 4'h0, 5'd5, 32'h12345678, 1'b0);
        setVec( 4, 3'b001, 15'd0, 12'h00F, {64'h0, 32'hDEADBEEF}, 1'b0,
                   3'b001, 2'd0, 4'h0, 5'd5, 32'h12345678, 1'b0);
        setVec( 5, 3'b000, 15'd0, 12'h0, 96'h0, 1'b0, 3'b000, 2'd0, 4'h0, 5'd0, 32'hDEADBEEF, 1'b1);
        setVec( 6, 3'b000, 15'd0, 12'h0, 96'h0, 1'b0, 3'b000, 2'd0, 4'h0, 5'd0, 32'hDEADBEEF, 1'b0);
        setVec( 7, 3'b010, {5'd0, 5'd9, 5'd0}, 12'h050, {32'h0, 32'hAABBCCDD, 32'h0}, 1'b0,
                   3'b010, 2'd1, 4'h0, 5'd0, 32'hDEADBEEF, 1'b0);
        setVec( 8, 3'b000, 15'd0, 12'h0, 96'h0, 1'b0, 3'b000, 2'd0, 4'h5, 5'd9, 32'hAABBCCDD, 1'b1);
        setVec( 9, 3'b111, ALL_ADDR, ALL_BE, ALL_DATA, 1'b0, 3'b100, 2'd2, 4'h0, 5'd9, 32'hAABBCCDD, 1'b0);
        setVec(10, 3'b111, ALL_ADDR, ALL_BE, ALL_DATA, 1'b0, 3'b001, 2'd0, 4'hF, 5'd3, 32'h300, 1'b1);
        setVec(11, 3'b111, ALL_ADDR, ALL_BE, ALL_DATA, 1'b0, 3'b010, 2'd1, 4'hF, 5'd1, 32'h100, 1'b1);
        setVec(12, 3'b111, ALL_ADDR, ALL_BE, ALL_DATA, 1'b1, 3'b000, 2'd0, 4'h0, 5'd2, 32'h200, 1'b1);
        setVec(13, 3'b111, ALL_ADDR, ALL_BE, ALL_DATA, 1'b1, 3'b000, 2'd0, 4'h0, 5'd2, 32'h200, 1'b1);
        setVec(14, 3'b111, ALL_ADDR, ALL_BE, ALL_DATA, 1'b1, 3'b000, 2'd0, 4'h0, 5'd2, 32'h200, 1'b1);
        setVec(15, 3'b000, 15'd0, 12'h0, 96'h0, 1'b0, 3'b000, 2'd0, 4'hF, 5'd2, 32'h200, 1'b1);
        setVec(16, 3'b000, 15'd0, 12'h0, 96'h0, 1'b0, 3'b000, 2'd0, 4'h0, 5'd2, 32'h200, 1'b0);

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].addr, vecs[i].be, vecs[i].data, vecs[i].hold);
            @(negedge clk);
            checkOutput($sformatf("vec%0d", i), vecs[i].expReady, vecs[i].expGid,
                        vecs[i].expWen, vecs[i].expAddr, vecs[i].expData, vecs[i].expBusy);
        end

        // Reset while the stage holds a write: pointer sits at 2 beforehand
        applyStimulus(3'b010, {5'd0, 5'd4, 5'd0}, 12'h0F0, {32'h0, 32'h44, 32'h0}, 1'b0);
        @(negedge clk);
        checkOutput("rst_load", 3'b010, 2'd1, 4'h0, 5'd2, 32'h200, 1'b0);
        applyStimulus(3'b000, 15'd0, 12'h0, 96'h0, 1'b0);
        @(negedge clk);
        checkOutput("rst_stage", 3'b000, 2'd0, 4'hF, 5'd4, 32'h44, 1'b1);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("rst_async", 3'b000, 2'd0, 4'h0, 5'd0, 32'h0, 1'b0);
        @(posedge clk);
        #2;
        resetn = 1'b1;
        @(negedge clk);
        checkOutput("rst_after", 3'b000, 2'd0, 4'h0, 5'd0, 32'h0, 1'b0);
        applyStimulus(3'b111, ALL_ADDR, ALL_BE, ALL_DATA, 1'b0);
        @(negedge clk);
        checkOutput("rst_grant0", 3'b001, 2'd0, 4'h0, 5'd0, 32'h0, 1'b0);

`ifdef RF_WB_FWD_EN
        // Forwarding: stage addr 7, be 0011 merges into read port 1 only
        applyStimulus(3'b001, {10'd0, 5'd7}, 12'h003, {64'h0, 32'h0000BEEF}, 1'b0);
        applyStimulus(3'b000, 15'd0, 12'h0, 96'h0, 1'b1);
        fwdRaddr1   = 5'd7;
        fwdRdata1In = 32'h11223344;
        fwdRaddr2   = 5'd6;
        fwdRdata2In = 32'h55667788;
        @(negedge clk);
        checkField("fwd_rdata1", fwdRdata1, 32'h1122BEEF);
        checkField("fwd_rdata2", fwdRdata2, 32'h55667788);
`endif

        // Fresh reset so the model starts from a known state
        @(posedge clk);
        #1;
        resetn   = 1'b0;
        reqValid = '0;
        hold     = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        mValid = 1'b0;
        mAddr  = '0;
        mBe    = '0;
        mData  = '0;
        mPtr   = 0;

        for (int c = 0; c < 400; c++) begin
            rv = 3'($urandom_range(0, 7));
            for (int i = 0; i < NREQ; i++) begin
                ra[i*5 +: 5]   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
                rb[i*4 +: 4]   = 4'($urandom_range(0, 15));
                rd[i*32 +: 32] = $urandom;
            end
            rh = ($urandom_range(0, 3) == 0);
            applyStimulus(rv, ra, rb, rd, rh);
            @(negedge clk);

            // Expected outputs: first valid requester at or after the pointer
            g = -1;
            for (int k = 0; k < NREQ; k++) begin
                idx = (mPtr + k) % NREQ;
                if (g < 0 && rv[idx]) g = idx;
            end
            acc  = !rh && (rv != 3'b000);
            expR = acc ? (3'b001 << g) : 3'b000;
            expG = acc ? g[1:0] : 2'd0;
            expW = (mValid && !rh) ? mBe : 4'h0;
            checkOutput($sformatf("rand%0d", c), expR, expG, expW, mAddr, mData, mValid);

            // Advance the model across the coming rising edge
            if (acc) begin
                mAddr  = ra[g*5 +: 5];
                mBe    = (ra[g*5 +: 5] == 5'd0) ? 4'h0 : rb[g*4 +: 4];
                mData  = rd[g*32 +: 32];
                mValid = 1'b1;
                mPtr   = (g + 1) % NREQ;
            end else if (mValid && !rh) begin
                mValid = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
